line_word_sequencer: RTL and testbench

- Accepts full memory lines (FULL_WIDTH bits) over a valid/ready handshake and emits a selected run of WIDTH-bit words over a second valid/ready handshake, one word per cycle.
- Sits between the memory read-response path and the PageRank edge/rank consumers.
- Takes a start word index and a word count with each line, so partially useful lines (unaligned edge lists, list tails) are unpacked without host intervention.
- Sustains one word per cycle across line boundaries, with no bubble.

---
 rtl/pagerank_pkg.sv | 23 ++
 rtl/line_word_sequencer_word_select.sv | 20 ++
 rtl/line_word_sequencer.sv | 153 +++++++++++++++
 tb/tb_line_word_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pagerank_pkg.sv
// Shared definitions for the PageRank memory-side datapath: line/word geometry
// defaults, the derived-geometry helpers and the line unpacker state encoding.
package pagerank_pkg;

    localparam int FULL_WIDTH_DEFAULT = 512;
    localparam int WIDTH_DEFAULT      = 64;
    localparam int CNT_W_DEFAULT      = 32;

    function automatic int words_of(input int full_width, input int width);
        return full_width / width;
    endfunction

    // A one-word line still needs a one-bit index so ports never collapse to zero width.
    function automatic int idx_w_of(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } seq_state_e;

endpackage

// File: rtl/line_word_sequencer_word_select.sv
// Combinational word mux: picks word idx out of a held memory line.
module word_select
    import pagerank_pkg::*;
#(
    parameter int FULL_WIDTH = FULL_WIDTH_DEFAULT,
    parameter int WIDTH      = WIDTH_DEFAULT,
    localparam int WORDS     = words_of(FULL_WIDTH, WIDTH),
    localparam int IDX_W     = idx_w_of(WORDS)
) (
    input  logic [FULL_WIDTH-1:0] held,
    input  logic [IDX_W-1:0]      idx,
    output logic [WIDTH-1:0]      word
);

    // Indexed part-select of the addressed word.
    always_comb begin
        word = held[WIDTH*idx +: WIDTH];
    end

endmodule

// File: rtl/line_word_sequencer.sv
// Unpacks a run of WIDTH-bit words from full memory lines, one word per cycle,
// with back-to-back line hand-over on the last-word handshake.
module line_word_sequencer
    import pagerank_pkg::*;
#(
    parameter int FULL_WIDTH = FULL_WIDTH_DEFAULT,
    parameter int WIDTH      = WIDTH_DEFAULT,
    parameter int CNT_W      = CNT_W_DEFAULT,
    localparam int WORDS     = words_of(FULL_WIDTH, WIDTH),
    localparam int IDX_W     = idx_w_of(WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  line_valid,
    output logic                  line_ready,
    input  logic [FULL_WIDTH-1:0] line_data,
    input  logic [IDX_W-1:0]      line_start,
    input  logic [IDX_W:0]        line_count,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic [WIDTH-1:0]      word_data,
    output logic [IDX_W-1:0]      word_idx,
    output logic                  word_last,
    output logic                  trunc_err,
    output logic [CNT_W-1:0]      words_emitted
);

    seq_state_e            state_q, state_d;
    logic [FULL_WIDTH-1:0] held_q, held_d;
    logic [IDX_W-1:0]      cur_q, cur_d;
    logic [IDX_W-1:0]      end_q, end_d;
    logic                  trunc_q, trunc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [IDX_W:0]        cnt_sat_s;
    logic [IDX_W:0]        room_s;
    logic [IDX_W:0]        eff_s;
    logic [IDX_W:0]        end_wide_s;
    logic [IDX_W+1:0]      span_s;
    logic                  accept_s;
    logic                  load_s;
    logic                  word_hs_s;

    // Effective run length of the line on the input port, clipped to the line end.
    always_comb begin
        if (line_count > (IDX_W+1)'(WORDS)) begin
            cnt_sat_s = (IDX_W+1)'(WORDS);
        end else begin
            cnt_sat_s = line_count;
        end
        room_s = (IDX_W+1)'(WORDS) - {1'b0, line_start};
        if (cnt_sat_s < room_s) begin
            eff_s = cnt_sat_s;
        end else begin
            eff_s = room_s;
        end
        span_s     = {2'b00, line_start} + {1'b0, line_count};
        end_wide_s = {1'b0, line_start} + eff_s - (IDX_W+1)'(1);
    end

    // Handshake decode; outputs come straight from registered state.
    always_comb begin
        word_valid = (state_q == EMIT);
        word_last  = (state_q == EMIT) && (cur_q == end_q);
        word_idx   = cur_q;
        line_ready = (state_q == IDLE) || (word_last && word_ready);
        accept_s   = line_valid && line_ready;
        load_s     = accept_s && (eff_s != (IDX_W+1)'(0));
        word_hs_s  = word_valid && word_ready;
    end

    word_select #(
        .FULL_WIDTH (FULL_WIDTH),
        .WIDTH      (WIDTH)
    ) u_word_select (
        .held (held_q),
        .idx  (cur_q),
        .word (word_data)
    );

    // Next-state logic: line load, word advance and end-of-line hand-over.
    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        cur_d   = cur_q;
        end_d   = end_q;
        case (state_q)
            IDLE: begin
                if (load_s) begin
                    state_d = EMIT;
                end else begin
                    state_d = IDLE;
                end
            end
            EMIT: begin
                if (word_hs_s && word_last) begin
                    if (load_s) begin
                        state_d = EMIT;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (word_hs_s) begin
                    cur_d = cur_q + IDX_W'(1);
                end else begin
                    state_d = EMIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // load_s already implies the FSM is free to take a new line this edge.
        if (load_s) begin
            held_d = line_data;
            cur_d  = line_start;
            end_d  = end_wide_s[IDX_W-1:0];
        end else begin
            held_d = held_d;
        end
    end

    // Sticky truncation flag and emitted-word statistics.
    always_comb begin
        if (accept_s && (span_s > (IDX_W+2)'(WORDS))) begin
            trunc_d = 1'b1;
        end else begin
            trunc_d = trunc_q;
        end
        cnt_d         = cnt_q + CNT_W'(word_hs_s);
        trunc_err     = trunc_q;
        words_emitted = cnt_q;
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            held_q  <= '0;
            cur_q   <= '0;
            end_q   <= '0;
            trunc_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            cur_q   <= cur_d;
            end_q   <= end_d;
            trunc_q <= trunc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_line_word_sequencer.sv
// Self-checking bench for line_word_sequencer: directed scenarios plus random
// traffic, scored against a queue-of-expected-words model.
module tb_line_word_sequencer;

    localparam int FW = 512;
    localparam int W  = 64;
    localparam int NW = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           line_valid = 1'b0;
    logic           line_ready;
    logic [FW-1:0]  line_data = '0;
    logic [2:0]     line_start = 3'd0;
    logic [3:0]     line_count = 4'd0;
    logic           word_valid;
    logic           word_ready = 1'b0;
    logic [W-1:0]   word_data;
    logic [2:0]     word_idx;
    logic           word_last;
    logic           trunc_err;
    logic [31:0]    words_emitted;

    typedef struct {
        logic [W-1:0] data;
        int           idx;
        bit           last;
    } exp_word_t;

    exp_word_t   exp_q[$];
    int unsigned m_cnt = 0;
    bit          m_trunc = 1'b0;
    int          total = 0;
    int          bad = 0;

    line_word_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .line_valid    (line_valid),
        .line_ready    (line_ready),
        .line_data     (line_data),
        .line_start    (line_start),
        .line_count    (line_count),
        .word_valid    (word_valid),
        .word_ready    (word_ready),
        .word_data     (word_data),
        .word_idx      (word_idx),
        .word_last     (word_last),
        .trunc_err     (trunc_err),
        .words_emitted (words_emitted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk_line(input logic [W-1:0] base);
        logic [FW-1:0] l;
        for (int i = 0; i < NW; i++) l[W*i +: W] = base + W'(i);
        return l;
    endfunction

    // Model of one accepted line: which words it contributes, in order.
    task automatic model_accept(input logic [FW-1:0] d, input int start, input int count);
        int sat, eff;
        sat = (count > NW) ? NW : count;
        if (start + count > NW) m_trunc = 1'b1;
        eff = (sat < NW - start) ? sat : NW - start;
        for (int k = 0; k < eff; k++) begin
            exp_word_t e;
            e.data = d[W*(start+k) +: W];
            e.idx  = start + k;
            e.last = (k == eff - 1);
            exp_q.push_back(e);
        end
    endtask

    // One clock: check outputs mid-cycle, advance the model, step past the edge.
    task automatic cycle();
        bit exp_lr;
        @(negedge clk);
        exp_lr = (exp_q.size() == 0) || (exp_q[0].last && word_ready);
        chk("word_valid", 64'(word_valid), 64'(exp_q.size() != 0));
        chk("line_ready", 64'(line_ready), 64'(exp_lr));
        chk("trunc_err", 64'(trunc_err), 64'(m_trunc));
        chk("words_emitted", 64'(words_emitted), 64'(m_cnt));
        if (exp_q.size() != 0) begin
            chk("word_data", word_data, exp_q[0].data);
            chk("word_idx", 64'(word_idx), 64'(exp_q[0].idx));
            chk("word_last", 64'(word_last), 64'(exp_q[0].last));
        end
        if (rst) begin
            exp_q.delete();
            m_cnt   = 0;
            m_trunc = 1'b0;
        end else begin
            if (exp_q.size() != 0 && word_ready) begin
                void'(exp_q.pop_front());
                m_cnt++;
            end
            if (line_valid && exp_lr) model_accept(line_data, int'(line_start), int'(line_count));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic put_line(input logic [W-1:0] base, input int start, input int count);
        line_valid = 1'b1;
        line_data  = mk_line(base);
        line_start = 3'(start);
        line_count = 4'(count);
    endtask

    initial begin
        // Reset and reset values.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_word_valid", 64'(word_valid), 64'd0);
        chk("rst_word_idx", 64'(word_idx), 64'd0);
        chk("rst_word_last", 64'(word_last), 64'd0);
        chk("rst_word_data", word_data, 64'd0);
        chk("rst_trunc", 64'(trunc_err), 64'd0);
        chk("rst_cnt", 64'(words_emitted), 64'd0);
        chk("rst_line_ready", 64'(line_ready), 64'd1);
        rst = 1'b0;
        word_ready = 1'b1;

        // start=2, count=3.
        put_line(64'h10, 2, 3);
        cycle();
        line_valid = 1'b0;
        repeat (4) cycle();
        chk("t1_words_emitted", 64'(words_emitted), 64'd3);

        // Two full lines back to back.
        put_line(64'h100, 0, 8);
        cycle();
        put_line(64'h200, 0, 8);
        repeat (8) cycle();
        line_valid = 1'b0;
        repeat (9) cycle();
        chk("t2_words_emitted", 64'(words_emitted), 64'd19);

        // Ready toggling on a count=4 line.
        put_line(64'h300, 1, 4);
        cycle();
        line_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            word_ready = (i % 2 == 1);
            cycle();
        end
        word_ready = 1'b1;
        cycle();

        // Truncated line, then a legal one.
        put_line(64'h400, 6, 4);
        cycle();
        line_valid = 1'b0;
        repeat (3) cycle();
        chk("t4_trunc_set", 64'(trunc_err), 64'd1);
        put_line(64'h500, 0, 2);
        cycle();
        line_valid = 1'b0;
        repeat (3) cycle();
        chk("t4_trunc_sticky", 64'(trunc_err), 64'd1);

        // Zero-count line followed by a single-word line.
        put_line(64'h600, 3, 0);
        cycle();
        put_line(64'h700, 0, 1);
        cycle();
        line_valid = 1'b0;
        repeat (3) cycle();

        // Reset during the second word of a count=5 line.
        put_line(64'h800, 0, 5);
        cycle();
        line_valid = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("t6_valid_after_rst", 64'(word_valid), 64'd0);
        chk("t6_cnt_after_rst", 64'(words_emitted), 64'd0);
        chk("t6_ready_after_rst", 64'(line_ready), 64'd1);
        cycle();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            line_valid = ($urandom_range(0, 2) != 0);
            for (int j = 0; j < FW / 32; j++) line_data[32*j +: 32] = $urandom;
            line_start = 3'($urandom_range(0, 7));
            line_count = 4'($urandom_range(0, 15));
            word_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        // Drain with a bounded cycle budget.
        line_valid = 1'b0;
        word_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) cycle();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
